// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = 4;

  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_DEPTH   = 1024;
  localparam int DEF_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word array with per-byte write enable and one registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we_i,
  input  logic [BYTES_PER_WORD-1:0] wmask_i,
  input  logic [ADDR_W-1:0]         addr_i,
  input  logic [WORD_W-1:0]         wdata_i,
  input  logic                      re_i,
  output logic [WORD_W-1:0]         rdata_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;
  logic [IDX_W-1:0]  idx;

  // Callers only enable accesses for in-range addresses, so the low bits suffice.
  assign idx = addr_i[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < BYTES_PER_WORD; b++) begin
        if (wmask_i[b]) begin
          mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[idx];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - handshaked multi-cycle data-memory slave with wait states.
// DMEM_BYTE_EN_EN enables byte-granular stores; otherwise every store writes the full word.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [WORD_W-1:0]         wdata,
  input  logic [BYTES_PER_WORD-1:0] be,
  output logic                      busy,
  output logic                      ack,
  output logic [WORD_W-1:0]         rdata,
  output logic                      err
);

  if (LATENCY < 0 || LATENCY > 15) begin : g_latency_check
    $error("dmem_responder: LATENCY must be within 0..15");
  end

  localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(LATENCY);
  localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W + 1)'(DEPTH);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      we_q, oor_q, ld_q;
  logic [ADDR_W-1:0]         addr_q;
  logic [WORD_W-1:0]         wdata_q;
  logic [BYTES_PER_WORD-1:0] be_q;
  logic                      enter_resp, capture;
  logic                      we_e, oor_e;
  logic [ADDR_W-1:0]         addr_e;
  logic [WORD_W-1:0]         wdata_e, arr_rdata;
  logic [BYTES_PER_WORD-1:0] be_e, wmask;

  // With zero wait states the access happens on the accepting edge, so take fields live.
  assign we_e    = (state_q == IDLE) ? we    : we_q;
  assign addr_e  = (state_q == IDLE) ? addr  : addr_q;
  assign wdata_e = (state_q == IDLE) ? wdata : wdata_q;
  assign be_e    = (state_q == IDLE) ? be    : be_q;
  assign oor_e   = {1'b0, addr_e} >= DEPTH_C;
  assign capture = (state_q == IDLE) && req;

`ifdef DMEM_BYTE_EN_EN
  assign wmask = be_e;
`else
  logic unused_be;
  assign unused_be = ^be_e;
  assign wmask     = '1;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d = LAT_C;
          if (LAT_C == '0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      oor_q   <= 1'b0;
      ld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        be_q    <= be;
      end
      if (enter_resp) begin
        oor_q <= oor_e;
        ld_q  <= !we_e && !oor_e;
      end
    end
  end

  dmem_array #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .we_i   (enter_resp && we_e && !oor_e),
    .wmask_i(wmask),
    .addr_i (addr_e),
    .wdata_i(wdata_e),
    .re_i   (enter_resp && !we_e && !oor_e),
    .rdata_o(arr_rdata)
  );

  assign busy  = (state_q != IDLE);
  assign ack   = (state_q == RESP);
  assign err   = ack && oor_q;
  assign rdata = ld_q ? arr_rdata : '0;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the processor's data-memory port. It replaces the zero-wait dm_4k model with a handshaked, multi-cycle slave. It accepts one load/store request at a time, inserts a configurable number of wait states, then completes the access with a one-cycle acknowledge. It sits between the CPU's load/store path (or a bus adapter) and a 4 KB word-organised storage array.

Parameters:
- ADDR_W, 10, word-address width (4 KB = 1024 words).
- DEPTH, 1024, implemented words; addresses at or above DEPTH are out of range.
- LATENCY, 2, wait states inserted between request acceptance and completion (0..15).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  request valid; held with fields stable until ack.
- we  in  1  1 = store, 0 = load.
- addr  in  ADDR_W  word address (byte address [11:2]).
- wdata  in  32  store data.
- be  in  4  byte enables, bit i = byte [8i+7:8i].
- busy  out  1  high while a transaction is in progress (not IDLE).
- ack  out  1  one-cycle completion pulse.
- rdata  out  32  load data, valid only in the ack cycle.
- err  out  1  high with ack when addr is out of range.

Behaviour:
- Reset (async, any state): state = IDLE; busy = 0, ack = 0, rdata = 0, err = 0, wait counter = 0.
  - An in-flight store is discarded and never committed.
  - Array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE: when req = 1 at a clock edge, latch we/addr/wdata/be and load counter = LATENCY.
  - Go to WAIT if LATENCY > 0, otherwise go to RESP.
- WAIT: counter decrements each cycle; when it reaches 1, go to RESP on the next edge.
- RESP (exactly one cycle): ack = 1, busy = 1; next state is IDLE.
- Latency: request sampled at edge t gives ack high during cycle t+LATENCY+1. Throughput is one transaction per LATENCY+2 cycles.
- Store commit: at the edge entering RESP, only bytes with be = 1 are written.
  - be = 4'b0000 produces ack but no write.
- Load: rdata captured at the edge entering RESP from the latched address.
  - rdata holds its value after ack, but is undefined to the requester outside the ack cycle.
  - rdata = 0 for stores.
- Out of range (latched addr >= DEPTH): no write; rdata = 0; err = 1 alongside ack.
- Ordering: a load following a store to the same address returns the stored data.
- Handshake rules:
  - req may stay high through ack. If req is still high in the cycle after RESP (IDLE), a new transaction starts; the requester must drop req or present new fields.
  - req and field changes while busy = 1 are ignored.
  - ack is never asserted without a prior accepted req.
- Counter width is 4 bits. LATENCY > 15 is illegal; an elaboration-time check flags it.

Optional Feature:
- DMEM_BYTE_EN_EN defined: be honoured as above; partial stores are possible.
- Not defined: be is ignored and every store writes all 32 bits. The be port remains present so the interface is unchanged.

Decomposition:
- Package dmem_pkg holds:
  - the state typedef (IDLE/WAIT/RESP);
  - word width 32 and bytes-per-word 4;
  - default ADDR_W/DEPTH/LATENCY constants;
  - the 4-bit counter width.
- One sub-module, dmem_array: synchronous word array with per-byte write enable, one registered read port, and DEPTH/ADDR_W parameters.
- The FSM, counter, range check and err/ack generation remain in dmem_responder.

Test Plan:
- Reset check: assert rst mid-WAIT of a store to addr 5 with wdata 0xDEADBEEF, release, then load addr 5.
  - Expect no ack for the aborted store, busy = 0 immediately on reset, and the loaded value equal to its pre-store content (e.g. 0x00000000 after a preload of zeros).
- LATENCY = 2: store 0x12345678 to addr 10, then load addr 10.
  - Expect ack exactly 3 cycles after each req sample.
  - Expect rdata = 0x12345678 in the load's ack cycle.
- Byte enables with DMEM_BYTE_EN_EN: preload addr 3 = 0xAABBCCDD, store 0x11223344 with be = 4'b0101, then load addr 3.
  - Expect 0xAA22CC44.
  - Without the macro, expect 0x11223344.
- Out of range: DEPTH = 512, store then load at addr 600.
  - Expect err = 1 with each ack, rdata = 0, and the array unchanged.
- Back-to-back traffic: hold req high across 4 consecutive loads with LATENCY = 0.
  - Expect ack every 2nd cycle and field changes during busy ignored.
- Boundary addresses: store then load addr 0 and addr DEPTH-1 with distinct patterns.
  - Expect correct readback and no aliasing between the two.
